// File: rtl/execute_load_ctrl.sv
// Single-outstanding load sequencer: execute request -> data-memory read -> writeback.
// Define EXECUTE_LOAD_ALIGN_CHECK_EN to fault misaligned half/word loads without a memory access.
module execute_load_ctrl #(
  parameter int P_DEST_W  = 5,
  parameter int P_TIMEOUT = 256
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iEVENT_FLUSH,
  input  logic                iREQ_VALID,
  output logic                oREQ_BUSY,
  input  logic [31:0]         iREQ_ADDR,
  input  logic [1:0]          iREQ_SIZE,
  input  logic [P_DEST_W-1:0] iREQ_DEST,
  output logic                oMEM_REQ,
  input  logic                iMEM_BUSY,
  output logic [31:0]         oMEM_ADDR,
  output logic [3:0]          oMEM_MASK,
  input  logic                iMEM_VALID,
  input  logic [31:0]         iMEM_DATA,
  output logic                oWB_VALID,
  input  logic                iWB_BUSY,
  output logic [31:0]         oWB_DATA,
  output logic [P_DEST_W-1:0] oWB_DEST,
  output logic                oWB_FAULT
);

  localparam int CNT_W = $clog2(P_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DATA,
    S_DRAIN
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  owed_q;
  logic [31:0]           addr_q;
  logic [3:0]            mask_q;
  logic [P_DEST_W-1:0]   dest_q;
  logic [31:0]           data_q;
  logic                  fault_q;

  logic [3:0]            mask_d;
  logic [31:0]           rdata_d;
  logic                  misalign_d;
  logic                  accept_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mask_d = 4'b1111;
    case (iREQ_SIZE)
      2'd0: begin
        case (iREQ_ADDR[1:0])
          2'd0:    mask_d = 4'b0001;
          2'd1:    mask_d = 4'b0010;
          2'd2:    mask_d = 4'b0100;
          default: mask_d = 4'b1000;
        endcase
      end
      2'd1:    mask_d = iREQ_ADDR[1] ? 4'b1100 : 4'b0011;
      default: mask_d = 4'b1111;
    endcase
  end

  // Lane bit0 is the most significant byte of the memory word.
  always_comb begin
    rdata_d = iMEM_DATA;
    case (mask_q)
      4'b0001: rdata_d = {24'd0, iMEM_DATA[31:24]};
      4'b0010: rdata_d = {24'd0, iMEM_DATA[23:16]};
      4'b0100: rdata_d = {24'd0, iMEM_DATA[15:8]};
      4'b1000: rdata_d = {24'd0, iMEM_DATA[7:0]};
      4'b0011: rdata_d = {16'd0, iMEM_DATA[31:16]};
      4'b1100: rdata_d = {16'd0, iMEM_DATA[15:0]};
      default: rdata_d = iMEM_DATA;
    endcase
  end

`ifdef EXECUTE_LOAD_ALIGN_CHECK_EN
  assign misalign_d = (iREQ_SIZE == 2'd1) ? iREQ_ADDR[0]
                    : (iREQ_SIZE[1] ? (iREQ_ADDR[1:0] != 2'b00) : 1'b0);
`else
  assign misalign_d = 1'b0;
`endif

  assign accept_d = iREQ_VALID & (state_q == S_IDLE) & ~iEVENT_FLUSH;

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
  // reset too so every output reads 0 straight out of reset.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owed_q  <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      dest_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else if (iEVENT_FLUSH) begin
      case (state_q)
        S_ISSUE: state_q <= S_IDLE;
        S_WAIT: begin
          // A response landing with the flush settles the debt; otherwise drain it later.
          if (iMEM_VALID) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DRAIN;
            owed_q  <= 1'b1;
          end
        end
        S_DATA:  state_q <= owed_q ? S_DRAIN : S_IDLE;
        default: state_q <= state_q;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            addr_q <= {iREQ_ADDR[31:2], 2'b00};
            mask_q <= mask_d;
            dest_q <= iREQ_DEST;
            if (misalign_d) begin
              state_q <= S_DATA;
              data_q  <= '0;
              fault_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!iMEM_BUSY) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (iMEM_VALID) begin
            state_q <= S_DATA;
            data_q  <= rdata_d;
            fault_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DATA;
            data_q  <= '0;
            fault_q <= 1'b1;
            owed_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (!iWB_BUSY) state_q <= owed_q ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          if (iMEM_VALID) begin
            state_q <= S_IDLE;
            owed_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oREQ_BUSY = (state_q != S_IDLE);
  assign oMEM_REQ  = (state_q == S_ISSUE);
  assign oMEM_ADDR = addr_q;
  assign oMEM_MASK = mask_q;
  assign oWB_VALID = (state_q == S_DATA);
  assign oWB_DATA  = data_q;
  assign oWB_DEST  = dest_q;
  assign oWB_FAULT = fault_q;

endmodule

// File: tb/tb_execute_load_ctrl.sv
// Bench for execute_load_ctrl: directed scenarios, then randomized traffic against a
// transaction-level model built from flags (request pending, awaiting data, result held, response owed).
module tb_execute_load_ctrl;

  localparam int DW  = 5;
  localparam int TMO = 12;
`ifdef EXECUTE_LOAD_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, req_valid, mem_busy, mem_valid, wb_busy;
  logic [31:0]   req_addr, mem_data;
  logic [1:0]    req_size;
  logic [DW-1:0] req_dest;
  logic          req_busy, mem_req, wb_valid, wb_fault;
  logic [31:0]   mem_addr, wb_data;
  logic [3:0]    mem_mask;
  logic [DW-1:0] wb_dest;

  execute_load_ctrl #(.P_DEST_W(DW), .P_TIMEOUT(TMO)) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .iEVENT_FLUSH(flush),
    .iREQ_VALID  (req_valid),
    .oREQ_BUSY   (req_busy),
    .iREQ_ADDR   (req_addr),
    .iREQ_SIZE   (req_size),
    .iREQ_DEST   (req_dest),
    .oMEM_REQ    (mem_req),
    .iMEM_BUSY   (mem_busy),
    .oMEM_ADDR   (mem_addr),
    .oMEM_MASK   (mem_mask),
    .iMEM_VALID  (mem_valid),
    .iMEM_DATA   (mem_data),
    .oWB_VALID   (wb_valid),
    .iWB_BUSY    (wb_busy),
    .oWB_DATA    (wb_data),
    .oWB_DEST    (wb_dest),
    .oWB_FAULT   (wb_fault)
  );

  int total = 0;
  int bad   = 0;
  int wb_beats = 0;

  always @(posedge clk) if (!rst && !flush && wb_valid && !wb_busy) wb_beats++;

  // Reference model state
  bit            m_req_pending, m_waiting, m_result_valid, m_resp_owed;
  int            m_waited;
  logic [31:0]   m_addr, m_res;
  logic [1:0]    m_size;
  logic [DW-1:0] m_dest;
  bit            m_res_fault;

  // Bench memory: one outstanding read with a response delay
  bit mem_out = 1'b0;
  int mem_timer = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] w);
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * (3 - int'(a[1:0]));
      return (w >> sh) & 32'h0000_00FF;
    end
    if (sz == 2'd1) begin
      sh = a[1] ? 0 : 16;
      return (w >> sh) & 32'h0000_FFFF;
    end
    return w;
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
    return ALIGN && (((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
  endfunction

  function automatic bit m_busy();
    return m_req_pending || m_waiting || m_result_valid || m_resp_owed;
  endfunction

  function automatic bit m_draining();
    return m_resp_owed && !m_waiting && !m_result_valid;
  endfunction

  task automatic model_reset();
    m_req_pending = 0; m_waiting = 0; m_result_valid = 0; m_resp_owed = 0;
    m_waited = 0; m_res_fault = 0;
  endtask

  task automatic model_advance();
    bit busy;
    bit drain;
    busy  = m_busy();
    drain = m_draining();
    if (rst) begin
      model_reset();
    end else if (flush) begin
      if (m_req_pending) m_req_pending = 0;
      else if (m_waiting) begin
        m_waiting = 0;
        if (mem_valid) m_resp_owed = 0;
      end else if (m_result_valid) m_result_valid = 0;
    end else if (!busy) begin
      if (req_valid) begin
        m_addr = req_addr; m_size = req_size; m_dest = req_dest;
        if (misaligned(req_addr, req_size)) begin
          m_result_valid = 1; m_res = 0; m_res_fault = 1;
        end else begin
          m_req_pending = 1;
        end
      end
    end else if (m_req_pending) begin
      if (!mem_busy) begin
        m_req_pending = 0; m_waiting = 1; m_resp_owed = 1; m_waited = 0;
      end
    end else if (m_waiting) begin
      if (mem_valid) begin
        m_res = pick(m_addr, m_size, mem_data); m_res_fault = 0;
        m_waiting = 0; m_resp_owed = 0; m_result_valid = 1;
      end else if (m_waited == TMO - 1) begin
        m_res = 0; m_res_fault = 1; m_waiting = 0; m_result_valid = 1;
      end else begin
        m_waited++;
      end
    end else if (m_result_valid) begin
      if (!wb_busy) m_result_valid = 0;
    end else if (drain && mem_valid) begin
      m_resp_owed = 0;
    end
  endtask

  task automatic check_outputs();
    check("req_busy", req_busy, m_busy());
    check("mem_req", mem_req, m_req_pending);
    check("wb_valid", wb_valid, m_result_valid);
    if (m_req_pending) begin
      check("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
      check("mem_mask", mem_mask, lane_mask(m_addr, m_size));
    end
    if (m_result_valid) begin
      check("wb_data", wb_data, m_res);
      check("wb_dest", 32'(wb_dest), 32'(m_dest));
      check("wb_fault", wb_fault, m_res_fault);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (!rst && !flush && m_req_pending && !mem_busy) begin
      mem_out   = 1'b1;
      mem_timer = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO - 2, TMO + 4) : $urandom_range(0, 3);
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; flush = 0; req_valid = 0; req_addr = '0; req_size = '0; req_dest = '0;
    mem_busy = 0; mem_valid = 0; mem_data = '0; wb_busy = 0;
  endtask

  task automatic request(input logic [31:0] a, input logic [1:0] sz, input logic [DW-1:0] d);
    quiet();
    req_valid = 1; req_addr = a; req_size = sz; req_dest = d;
    step();
    quiet();
  endtask

  task automatic simple_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] w, input logic [3:0] xmask,
                             input logic [31:0] xaddr, input logic [31:0] xdata);
    request(a, sz, 5'd9);
    check({tag, "_mask"}, mem_mask, xmask);
    check({tag, "_addr"}, mem_addr, xaddr);
    step();
    mem_valid = 1; mem_data = w;
    step();
    quiet();
    check({tag, "_wb_valid"}, wb_valid, 1);
    check({tag, "_wb_data"}, wb_data, xdata);
    check({tag, "_wb_dest"}, 32'(wb_dest), 32'd9);
    step();
    check({tag, "_idle"}, req_busy, 0);
  endtask

  task automatic drive_random();
    rst       = ($urandom_range(0, 299) == 0);
    req_valid = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    req_dest  = DW'($urandom);
    mem_busy  = ($urandom_range(0, 2) == 0);
    wb_busy   = ($urandom_range(0, 2) == 0);
    flush     = ($urandom_range(0, 24) == 0);
    mem_valid = 0;
    mem_data  = $urandom;
    if (mem_out) begin
      if (mem_timer > 0) mem_timer--;
      else if (m_waiting || m_draining()) begin
        mem_valid = 1; mem_out = 0;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_valid = 1;
    end
    if (flush && m_req_pending) mem_busy = 1;
    if (flush && mem_valid && m_draining()) flush = 0;
    if (rst) mem_out = 0;
  endtask

  initial begin
    int b0;
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    check("rst_req_busy", req_busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_mask", mem_mask, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_dest", 32'(wb_dest), 0);
    check("rst_wb_fault", wb_fault, 0);
    step();

    simple_load("byte", 32'h1003, 2'd0, 32'hAABB_CCDD, 4'b1000, 32'h1000, 32'h0000_00DD);
    simple_load("half_hi", 32'h2002, 2'd1, 32'h1122_3344, 4'b1100, 32'h2000, 32'h0000_3344);
    simple_load("half_lo", 32'h2000, 2'd1, 32'h1122_3344, 4'b0011, 32'h2000, 32'h0000_1122);

    // Memory and writeback back-pressure
    b0 = wb_beats;
    request(32'h4000, 2'd2, 5'd3);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_mem_req_held", mem_req, 1);
      check("bp_mem_addr_held", mem_addr, 32'h4000);
    end
    mem_busy = 0;
    step();
    mem_valid = 1; mem_data = 32'hCAFE_F00D;
    step();
    quiet();
    wb_busy = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_wb_valid_held", wb_valid, 1);
      check("bp_wb_data_held", wb_data, 32'hCAFE_F00D);
    end
    wb_busy = 0;
    step();
    check("bp_wb_done", wb_valid, 0);
    check("bp_one_beat", wb_beats - b0, 1);

    // Flush while waiting; response arrives two cycles later and is drained
    request(32'h5004, 2'd2, 5'd1);
    step();
    flush = 1;
    step();
    quiet();
    check("fl_wb_valid", wb_valid, 0);
    check("fl_draining_busy", req_busy, 1);
    step();
    mem_valid = 1; mem_data = 32'h1234_5678;
    step();
    quiet();
    check("fl_idle_after_resp", req_busy, 0);
    check("fl_no_wb", wb_valid, 0);

    // Flush blocks acceptance in IDLE, and cancels ISSUE
    flush = 1; req_valid = 1; req_addr = 32'h6000; req_size = 2'd2;
    step();
    quiet();
    check("fl_idle_no_accept", req_busy, 0);
    request(32'h6000, 2'd2, 5'd2);
    flush = 1; mem_busy = 1;
    step();
    quiet();
    check("fl_issue_mem_req", mem_req, 0);
    check("fl_issue_idle", req_busy, 0);

    // Timeout, then the late response is drained
    request(32'h7000, 2'd2, 5'd4);
    step();
    for (int i = 0; i < TMO - 1; i++) step();
    check("to_not_yet", wb_valid, 0);
    step();
    check("to_wb_valid", wb_valid, 1);
    check("to_fault", wb_fault, 1);
    check("to_data", wb_data, 0);
    step();
    check("to_drain_busy", req_busy, 1);
    step();
    mem_valid = 1; mem_data = 32'hDEAD_BEEF;
    step();
    quiet();
    check("to_idle", req_busy, 0);
    check("to_no_wb", wb_valid, 0);

    // Reset mid-operation; the in-flight response is ignored
    request(32'h8000, 2'd0, 5'd5);
    step();
    rst = 1;
    step();
    quiet();
    check("rm_idle", req_busy, 0);
    mem_valid = 1; mem_data = 32'h0101_0101;
    step();
    quiet();
    check("rm_ignored_busy", req_busy, 0);
    check("rm_ignored_wb", wb_valid, 0);

    // Misaligned word
    request(32'h3001, 2'd2, 5'd6);
    if (ALIGN) begin
      check("mis_no_mem_req", mem_req, 0);
      check("mis_fault", wb_fault, 1);
      check("mis_wb_valid", wb_valid, 1);
      step();
    end else begin
      check("mis_mask", mem_mask, 4'b1111);
      check("mis_addr", mem_addr, 32'h3000);
      step();
      mem_valid = 1; mem_data = 32'h0BAD_CAFE;
      step();
      quiet();
      check("mis_data", wb_data, 32'h0BAD_CAFE);
      check("mis_no_fault", wb_fault, 0);
      step();
    end

    // Randomized traffic
    mem_out = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
